mac_table_ctrl: RTL and testbench
=================================

Name: mac_table_ctrl

Overview:
- Controller sequencing the MAC-learning CAM of the L2 switch.
- Arbitrates a lookup requester (destination MAC) and a learn requester (source MAC + ingress port) onto the CAM's single compare bus and single write port.
- Owns the per-entry valid/port/age state, allocates free CAM entries, and runs an age sweep that deletes stale entries.
- Sits between the frame-parser front end and the CAM instance.

Parameters:
- MAC_WIDTH, 48, CAM key width; equals the CAM DATA_WIDTH.
- ADDR_WIDTH, 5, log2 table entries; equals the CAM ADDR_WIDTH.
- PORT_WIDTH, 2, switch port index width.
- CMP_LATENCY, 1, cycles from compare_data driven to match/match_addr valid (1..4).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- lkp_valid  in  1  lookup request
- lkp_ready  out  1  lookup accepted this cycle
- lkp_mac  in  MAC_WIDTH  destination MAC
- res_valid  out  1  one-cycle lookup result strobe
- res_hit  out  1  lookup hit
- res_port  out  PORT_WIDTH  port of hit entry; 0 on miss
- lrn_valid  in  1  learn request
- lrn_ready  out  1  learn accepted this cycle
- lrn_mac  in  MAC_WIDTH  source MAC
- lrn_port  in  PORT_WIDTH  ingress port
- lrn_drop  out  1  one-cycle pulse: learn discarded, table full
- age_tick  in  1  one-cycle aging-epoch pulse
- entry_count  out  ADDR_WIDTH+1  number of valid entries
- cam_write_addr  out  ADDR_WIDTH  CAM write address
- cam_write_data  out  MAC_WIDTH  CAM write key
- cam_write_delete  out  1  CAM delete
- cam_write_enable  out  1  CAM write strobe
- cam_write_busy  in  1  CAM write in progress
- cam_compare_data  out  MAC_WIDTH  CAM search key
- cam_match  in  1  CAM match
- cam_match_addr  in  ADDR_WIDTH  CAM match index

Behaviour:
- Reset (async, rst=1): all outputs 0; valid/age bit vectors 0; port table 0; FSM in IDLE; sweep pending 0; last grant = learn, so lookup wins the first tie.
- FSM states: IDLE, CMP, LRN_WR, WR_WAIT, AGE.
- IDLE, arbitration:
  - Only one requester valid -> grant it.
  - Both valid -> grant the one not granted last (alternating).
  - Grant: ready high for exactly one cycle; the MAC and port are latched; next state CMP.
  - ready is never high outside IDLE, nor while cam_write_busy=1.
- CMP: cam_compare_data holds the latched key. A wait counter runs CMP_LATENCY cycles, then cam_match/cam_match_addr are sampled. An entry is a hit only if cam_match=1 and valid[addr]=1.
- Lookup timing: accepted at cycle T -> res_valid at T+1+CMP_LATENCY.
  - res_hit and res_port reflect the hit.
  - On a hit, age[addr]=1.
  - Return to IDLE.
- Learn on hit: port[addr]=lrn_port, age[addr]=1, no CAM write, return to IDLE.
- Learn on miss with a free entry:
  - Free entry = lowest index with valid=0.
  - LRN_WR: cam_write_enable=1 for one cycle, cam_write_delete=0, addr = free entry, data = key.
  - Set valid=1, port=lrn_port, age=1; entry_count+1.
  - WR_WAIT until cam_write_busy=0, then IDLE.
- Learn on miss, table full: lrn_drop pulses at the sample cycle; no state change.
- Aging:
  - age_tick sets sweep pending. A tick arriving while a sweep is pending or running merges into it; it does not start a second sweep.
  - When pending and no request is valid in IDLE, enter AGE and process one entry per visit at the sweep pointer:
    - valid & age=1 -> clear age.
    - valid & age=0 -> cam_write_enable=1, cam_write_delete=1 for one cycle; valid=0; entry_count-1; WR_WAIT.
    - invalid -> skip.
  - The pointer increments and wraps 2**ADDR_WIDTH-1 -> 0; wrap clears pending.
  - Requests preempt the sweep between entries; the pointer is retained.
- Simultaneous events: a hit's age set and a sweep clear never target the same cycle (the FSM serialises them). entry_count saturates at 0 and 2**ADDR_WIDTH.
- cam_write_* change only in LRN_WR/AGE; otherwise enable=0 and delete=0.
- Reset mid-write abandons the operation. The CAM shares rst, so tables stay coherent.

Decomposition:
- Shared header/package mac_table_defs: FSM state encodings, MAC_WIDTH default, broadcast/miss port constant (0).
- One sub-module: mac_table_free_enc, a combinational lowest-index-zero priority encoder over the valid vector with a full flag.
- Valid/age bits and the port table stay as registers in the top level.

Test Plan:
- Reset, then learn MAC 00:11:22:33:44:55 on port 2 -> CAM write addr 0, data 0x001122334455, delete=0; entry_count=1. Then lookup of the same MAC -> res_hit=1, res_port=2 at T+1+CMP_LATENCY.
- Lookup of unlearned MAC 0xAABBCCDDEEFF -> res_valid=1, res_hit=0, res_port=0; no CAM write.
- lkp_valid and lrn_valid held together for 4 grants -> grants alternate lookup, learn, lookup, learn; never both ready in one cycle.
- Fill 32 entries, then learn a 33rd new MAC -> lrn_drop=1 pulse, entry_count=32, no CAM write. Relearn entry 5's MAC on port 3 -> port updated with no CAM write.
- Learn 3 MACs, one age_tick, lookup MAC#1, second age_tick -> first sweep clears ages only. Second sweep deletes entries 1 and 2 (write_delete=1) and keeps entry 0; entry_count=1.
- Assert rst while in WR_WAIT with cam_write_busy=1 -> all outputs 0 immediately; entry_count=0; a following lookup of the previously written MAC misses.

Source files
------------

// File: rtl/mac_table_ctrl_pkg.sv
// Shared definitions for the MAC-learning table controller.
package mac_table_defs;
  localparam int MAC_WIDTH_DEF = 48;
  localparam int MISS_PORT     = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMP     = 3'd1,
    ST_LRN_WR  = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_AGE     = 3'd4
  } state_t;
endpackage

// File: rtl/mac_table_ctrl_free_enc.sv
// Lowest-index free-entry encoder over the table valid vector.
module mac_table_free_enc #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [(1<<ADDR_WIDTH)-1:0] valid,
  output logic [ADDR_WIDTH-1:0]      free_idx,
  output logic                       full
);
  // Scan from the top down so the lowest clear bit wins.
  always_comb begin
    free_idx = {ADDR_WIDTH{1'b0}};
    full     = &valid;
    for (int i = (1 << ADDR_WIDTH) - 1; i >= 0; i--) begin
      free_idx = valid[i] ? free_idx : ADDR_WIDTH'(i);
    end
  end
endmodule

// File: rtl/mac_table_ctrl.sv
// Sequences lookups, learns and the age sweep onto a single-ported MAC CAM,
// owning the per-entry valid/age/port state.
module mac_table_ctrl
  import mac_table_defs::*;
#(
  parameter int MAC_WIDTH   = MAC_WIDTH_DEF,
  parameter int ADDR_WIDTH  = 5,
  parameter int PORT_WIDTH  = 2,
  parameter int CMP_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lkp_valid,
  output logic                  lkp_ready,
  input  logic [MAC_WIDTH-1:0]  lkp_mac,
  output logic                  res_valid,
  output logic                  res_hit,
  output logic [PORT_WIDTH-1:0] res_port,
  input  logic                  lrn_valid,
  output logic                  lrn_ready,
  input  logic [MAC_WIDTH-1:0]  lrn_mac,
  input  logic [PORT_WIDTH-1:0] lrn_port,
  output logic                  lrn_drop,
  input  logic                  age_tick,
  output logic [ADDR_WIDTH:0]   entry_count,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [MAC_WIDTH-1:0]  cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [MAC_WIDTH-1:0]  cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr
);
  localparam int ENTRIES = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH+1)'(ENTRIES);

  state_t                 state, state_nxt;
  logic [ENTRIES-1:0]     valid, age;
  logic [PORT_WIDTH-1:0]  port_tbl [ENTRIES];
  logic [MAC_WIDTH-1:0]   key;
  logic [PORT_WIDTH-1:0]  key_port;
  logic                   key_lrn, last_lrn, sweep_pending;
  logic [2:0]             wait_cnt;
  logic [ADDR_WIDTH-1:0]  wr_addr, sweep_ptr, free_idx;
  logic                   table_full, grant_lkp, grant_lrn, sample, hit, age_del;

  mac_table_free_enc #(.ADDR_WIDTH(ADDR_WIDTH)) u_free_enc (
    .valid    (valid),
    .free_idx (free_idx),
    .full     (table_full)
  );

  assign sample    = (state == ST_CMP) && (wait_cnt == 3'(CMP_LATENCY));
  assign hit       = cam_match && valid[cam_match_addr];
  assign age_del   = (state == ST_AGE) && valid[sweep_ptr] && !age[sweep_ptr];
  assign lkp_ready = grant_lkp;
  assign lrn_ready = grant_lrn;
  assign res_valid = sample && !key_lrn;
  assign res_hit   = res_valid && hit;
  assign res_port  = res_hit ? port_tbl[cam_match_addr] : PORT_WIDTH'(MISS_PORT);
  assign lrn_drop  = sample && key_lrn && !hit && table_full;
  assign cam_compare_data = key;

  // Arbitration: on a tie, grant whichever side was not served last.
  always_comb begin
    grant_lkp = 1'b0;
    grant_lrn = 1'b0;
    if (state == ST_IDLE && !cam_write_busy) begin
      if (lkp_valid && lrn_valid) begin
        grant_lkp = last_lrn;
        grant_lrn = !last_lrn;
      end else begin
        grant_lkp = lkp_valid;
        grant_lrn = lrn_valid;
      end
    end else begin
      grant_lkp = 1'b0;
      grant_lrn = 1'b0;
    end
  end

  // Next state and CAM write port drive.
  always_comb begin
    state_nxt        = state;
    cam_write_enable = 1'b0;
    cam_write_delete = 1'b0;
    cam_write_addr   = {ADDR_WIDTH{1'b0}};
    cam_write_data   = {MAC_WIDTH{1'b0}};
    case (state)
      ST_IDLE: begin
        if (grant_lkp || grant_lrn) begin
          state_nxt = ST_CMP;
        end else if (sweep_pending && !lkp_valid && !lrn_valid && !cam_write_busy) begin
          state_nxt = ST_AGE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CMP: begin
        if (sample) begin
          state_nxt = (key_lrn && !hit && !table_full) ? ST_LRN_WR : ST_IDLE;
        end else begin
          state_nxt = ST_CMP;
        end
      end
      ST_LRN_WR: begin
        cam_write_enable = 1'b1;
        cam_write_addr   = wr_addr;
        cam_write_data   = key;
        state_nxt        = ST_WR_WAIT;
      end
      ST_WR_WAIT: state_nxt = cam_write_busy ? ST_WR_WAIT : ST_IDLE;
      ST_AGE: begin
        if (age_del) begin
          cam_write_enable = 1'b1;
          cam_write_delete = 1'b1;
          cam_write_addr   = sweep_ptr;
          state_nxt        = ST_WR_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Controller registers, request latch and per-entry table state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      valid         <= {ENTRIES{1'b0}};
      age           <= {ENTRIES{1'b0}};
      key           <= {MAC_WIDTH{1'b0}};
      key_port      <= {PORT_WIDTH{1'b0}};
      key_lrn       <= 1'b0;
      last_lrn      <= 1'b1;
      sweep_pending <= 1'b0;
      wait_cnt      <= 3'd0;
      wr_addr       <= {ADDR_WIDTH{1'b0}};
      sweep_ptr     <= {ADDR_WIDTH{1'b0}};
      entry_count   <= {(ADDR_WIDTH+1){1'b0}};
      for (int i = 0; i < ENTRIES; i++) port_tbl[i] <= {PORT_WIDTH{1'b0}};
    end else begin
      state <= state_nxt;
      if (grant_lkp || grant_lrn) begin
        key      <= grant_lkp ? lkp_mac : lrn_mac;
        key_port <= lrn_port;
        key_lrn  <= grant_lrn;
        last_lrn <= grant_lrn;
        wait_cnt <= 3'd0;
      end else if (state == ST_CMP && !sample) begin
        wait_cnt <= wait_cnt + 3'd1;
      end
      if (sample) begin
        if (hit) begin
          age[cam_match_addr] <= 1'b1;
          if (key_lrn) port_tbl[cam_match_addr] <= key_port;
        end else if (key_lrn && !table_full) begin
          wr_addr <= free_idx;
        end
      end
      if (state == ST_LRN_WR) begin
        valid[wr_addr]    <= 1'b1;
        age[wr_addr]      <= 1'b1;
        port_tbl[wr_addr] <= key_port;
        if (entry_count != COUNT_MAX) entry_count <= entry_count + 1'b1;
      end
      if (state == ST_AGE) begin
        if (valid[sweep_ptr] && age[sweep_ptr]) begin
          age[sweep_ptr] <= 1'b0;
        end else if (age_del) begin
          valid[sweep_ptr] <= 1'b0;
          if (entry_count != {(ADDR_WIDTH+1){1'b0}}) entry_count <= entry_count - 1'b1;
        end
        sweep_ptr <= sweep_ptr + 1'b1;
      end
      // Ticks during a pending or running sweep fold into it; wrap ends it.
      if (state == ST_AGE && (&sweep_ptr)) begin
        sweep_pending <= 1'b0;
      end else if (age_tick) begin
        sweep_pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mac_table_ctrl.sv
// Directed and randomized checks of mac_table_ctrl against a table-level model.
module tb_mac_table_ctrl;
  localparam int L = 1;
  localparam int N = 32;

  logic        clk = 1'b0, rst = 1'b0;
  logic        lkp_valid = 1'b0, lrn_valid = 1'b0, age_tick = 1'b0;
  logic [47:0] lkp_mac = 48'd0, lrn_mac = 48'd0;
  logic [1:0]  lrn_port = 2'd0;
  logic        lkp_ready, lrn_ready, res_valid, res_hit, lrn_drop;
  logic [1:0]  res_port;
  logic [5:0]  entry_count;
  logic [4:0]  cam_write_addr, cam_match_addr;
  logic [47:0] cam_write_data, cam_compare_data;
  logic        cam_write_delete, cam_write_enable, cam_write_busy, cam_match;

  mac_table_ctrl #(.MAC_WIDTH(48), .ADDR_WIDTH(5), .PORT_WIDTH(2), .CMP_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_mac(lkp_mac),
    .res_valid(res_valid), .res_hit(res_hit), .res_port(res_port),
    .lrn_valid(lrn_valid), .lrn_ready(lrn_ready), .lrn_mac(lrn_mac), .lrn_port(lrn_port),
    .lrn_drop(lrn_drop), .age_tick(age_tick), .entry_count(entry_count),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_write_busy(cam_write_busy), .cam_compare_data(cam_compare_data),
    .cam_match(cam_match), .cam_match_addr(cam_match_addr)
  );

  always #5 clk = ~clk;

  // CAM environment: keyed storage, L-cycle compare pipeline, random write busy.
  logic [47:0] cam_key [N];
  logic        cam_v   [N];
  logic [47:0] cmp_pipe [L];
  int          busy_cnt;
  assign cam_write_busy = (busy_cnt != 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= 0;
      for (int i = 0; i < N; i++) begin cam_key[i] <= 48'd0; cam_v[i] <= 1'b0; end
      for (int i = 0; i < L; i++) cmp_pipe[i] <= 48'd0;
    end else begin
      cmp_pipe[0] <= cam_compare_data;
      for (int i = 1; i < L; i++) cmp_pipe[i] <= cmp_pipe[i-1];
      if (cam_write_enable) begin
        cam_key[cam_write_addr] <= cam_write_data;
        cam_v[cam_write_addr]   <= !cam_write_delete;
        busy_cnt <= int'($urandom_range(3, 1));
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  always_comb begin
    cam_match = 1'b0;
    cam_match_addr = 5'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cam_v[i] && cam_key[i] == cmp_pipe[L-1]) begin
        cam_match = 1'b1;
        cam_match_addr = 5'(i);
      end
    end
  end

  // Observers of write-port activity and drop pulses.
  logic [53:0] wr_q [$];
  int          drop_cnt = 0;
  always @(negedge clk) begin
    if (cam_write_enable) wr_q.push_back({cam_write_delete, cam_write_addr, cam_write_data});
    if (lrn_drop) drop_cnt++;
  end

  // Reference table model.
  bit          m_valid [N];
  bit          m_age   [N];
  logic [47:0] m_mac   [N];
  logic [1:0]  m_port  [N];
  int          m_count;
  bit          m_last_lrn;
  logic [53:0] exp_wr [$];

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_age[i] = 0; m_mac[i] = 48'd0; m_port[i] = 2'd0; end
    m_count = 0;
    m_last_lrn = 1;
    exp_wr.delete();
  endtask

  function automatic int m_find(input logic [47:0] mac);
    for (int i = 0; i < N; i++) if (m_valid[i] && m_mac[i] == mac) return i;
    return -1;
  endfunction

  // Applies a learn to the model; returns whether a drop is expected.
  task automatic m_learn(input logic [47:0] mac, input logic [1:0] port, output bit drop);
    int idx;
    drop = 0;
    idx = m_find(mac);
    if (idx >= 0) begin
      m_port[idx] = port; m_age[idx] = 1;
    end else if (m_count < N) begin
      idx = 0;
      while (m_valid[idx]) idx++;
      m_valid[idx] = 1; m_age[idx] = 1; m_mac[idx] = mac; m_port[idx] = port; m_count++;
      exp_wr.push_back({1'b0, 5'(idx), mac});
    end else begin
      drop = 1;
    end
    m_last_lrn = 1;
  endtask

  task automatic m_sweep();
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_age[i]) m_age[i] = 0;
      else if (m_valid[i]) begin
        m_valid[i] = 0; m_count--;
        exp_wr.push_back({1'b1, 5'(i), 48'd0});
      end
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) chk({tag, "_wr"}, 64'(wr_q[i]), 64'(exp_wr[i]));
    chk({tag, "_entry_count"}, 64'(entry_count), 64'(m_count));
    wr_q.delete();
    exp_wr.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; lkp_valid = 0; lrn_valid = 0; age_tick = 0;
    @(posedge clk); #1;
    rst = 0;
    m_reset();
    @(negedge clk);
    wr_q.delete();
  endtask

  task automatic do_lookup(input logic [47:0] mac, input string tag);
    int idx, lat;
    bit ok;
    idx = m_find(mac);
    @(posedge clk); #1;
    lkp_mac = mac; lkp_valid = 1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = lkp_ready; end
    chk({tag, "_grant"}, 64'(ok), 64'd1);
    @(posedge clk); #1;
    lkp_valid = 0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin @(negedge clk); if (res_valid) lat = i; end
    chk({tag, "_latency"}, 64'(lat), 64'(1 + L));
    chk({tag, "_hit"}, 64'(res_hit), 64'(idx >= 0));
    chk({tag, "_port"}, 64'(res_port), (idx >= 0) ? 64'(m_port[idx]) : 64'd0);
    if (idx >= 0) m_age[idx] = 1;
    m_last_lrn = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_learn(input logic [47:0] mac, input logic [1:0] port, input string tag);
    bit ok, drop;
    int d0;
    d0 = drop_cnt;
    wr_q.delete();
    @(posedge clk); #1;
    lrn_mac = mac; lrn_port = port; lrn_valid = 1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = lrn_ready; end
    chk({tag, "_grant"}, 64'(ok), 64'd1);
    @(posedge clk); #1;
    lrn_valid = 0;
    repeat (12) @(negedge clk);
    m_learn(mac, port, drop);
    chk({tag, "_drop"}, 64'(drop_cnt - d0), 64'(drop));
    check_writes(tag);
  endtask

  task automatic do_age(input string tag);
    wr_q.delete();
    @(posedge clk); #1; age_tick = 1;
    @(posedge clk); #1; age_tick = 0;
    repeat (150) @(negedge clk);
    m_sweep();
    check_writes(tag);
  endtask

  logic [47:0] macs [N];
  logic [47:0] mac_a, mac_b, mac_x;
  bit          gq [$];
  int          both, idx;
  bit          drop;

  initial begin
    m_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({lkp_ready, lrn_ready, res_valid, res_hit, res_port, lrn_drop,
        cam_write_enable, cam_write_delete, cam_write_addr}), 64'd0);
    chk("reset_cam_data", 64'(cam_write_data | cam_compare_data), 64'd0);
    chk("reset_entry_count", 64'(entry_count), 64'd0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);

    mac_a = 48'h001122334455;
    do_learn(mac_a, 2'd2, "learn_first");
    do_lookup(mac_a, "lookup_first");
    wr_q.delete();
    do_lookup(48'hAABBCCDDEEFF, "lookup_unknown");
    check_writes("lookup_unknown");

    // Both requesters held: four grants must alternate.
    mac_b = 48'h0000DEADBEEF;
    @(posedge clk); #1;
    lkp_mac = mac_a; lkp_valid = 1; lrn_mac = mac_b; lrn_port = 2'd1; lrn_valid = 1;
    gq.delete(); both = 0;
    for (int c = 0; c < 300 && gq.size() < 4; c++) begin
      @(negedge clk);
      if (lkp_ready && lrn_ready) both++;
      if (lkp_ready) gq.push_back(1'b0);
      else if (lrn_ready) gq.push_back(1'b1);
      if (gq.size() == 4) begin @(posedge clk); #1; lkp_valid = 0; lrn_valid = 0; end
    end
    lkp_valid = 0; lrn_valid = 0;
    repeat (12) @(negedge clk);
    chk("alt_grants", 64'(gq.size()), 64'd4);
    chk("alt_both_ready", 64'(both), 64'd0);
    for (int k = 0; k < gq.size(); k++) begin
      chk("alt_order", 64'(gq[k]), 64'((m_last_lrn ? 1'b0 : 1'b1) ^ 1'(k)));
    end
    for (int k = 0; k < gq.size(); k++) begin
      if (gq[k]) m_learn(mac_b, 2'd1, drop);
      else begin idx = m_find(mac_a); if (idx >= 0) m_age[idx] = 1; m_last_lrn = 0; end
    end
    check_writes("alt");

    // Fill the table, overflow, relearn, then random lookups.
    do_reset();
    for (int i = 0; i < N; i++) begin
      macs[i] = {8'(i), 8'hC3, 32'($urandom)};
      do_learn(macs[i], 2'($urandom_range(3, 0)), "fill");
    end
    chk("full_count", 64'(entry_count), 64'd32);
    do_learn(48'hFEEDFACE0001, 2'd1, "overflow");
    do_learn(macs[5], 2'd3, "relearn5");
    do_lookup(macs[5], "lookup5");
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(1, 0) == 1) do_lookup(macs[$urandom_range(N - 1, 0)], "rand_known");
      else begin
        mac_x = {8'hEE, 40'($urandom)};
        do_lookup(mac_x, "rand_unknown");
      end
      if ($urandom_range(3, 0) == 0) do_learn(macs[$urandom_range(N - 1, 0)], 2'($urandom_range(3, 0)), "rand_relearn");
    end

    // Aging: first sweep clears ages, second deletes unrefreshed entries.
    do_reset();
    for (int i = 0; i < 3; i++) do_learn({16'h0A0B, 32'(i * 7 + 1)}, 2'(i + 1), "age_learn");
    do_age("sweep1");
    do_lookup({16'h0A0B, 32'd1}, "age_refresh");
    do_age("sweep2");
    chk("aged_count", 64'(entry_count), 64'd1);
    do_lookup({16'h0A0B, 32'd8}, "aged_out");
    do_lookup({16'h0A0B, 32'd1}, "aged_kept");

    // Reset while waiting on a busy CAM write.
    do_reset();
    mac_x = 48'h123456789ABC;
    @(posedge clk); #1;
    lrn_mac = mac_x; lrn_port = 2'd3; lrn_valid = 1;
    @(posedge clk); #1; lrn_valid = 0;
    for (int i = 0; i < 20 && !cam_write_enable; i++) @(negedge clk);
    chk("midwr_enable", 64'(cam_write_enable), 64'd1);
    @(posedge clk); #1;
    chk("midwr_busy", 64'(cam_write_busy), 64'd1);
    rst = 1;
    #1;
    chk("midwr_reset_outputs", 64'({lkp_ready, lrn_ready, res_valid, res_hit, res_port, lrn_drop,
        cam_write_enable, cam_write_delete, cam_write_addr}), 64'd0);
    chk("midwr_entry_count", 64'(entry_count), 64'd0);
    @(posedge clk); #1; rst = 0;
    m_reset();
    do_lookup(mac_x, "midwr_lookup");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
